// File: rtl/wb_port_arbiter_if.sv
// Writeback-port arbiter bus: pipeline writeback request, multi-cycle
// result channel, registered register-file write port and FIFO occupancy.
// slave  = arbiter view, master = pipeline / mul-div / register-file view.
interface wb_port_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic                    pl_rf_en;
  logic [4:0]              pl_rd;
  logic [XLEN-1:0]         pl_wdata;
  logic                    pl_stall;
  logic                    mc_valid;
  logic                    mc_ready;
  logic [4:0]              mc_rd;
  logic [XLEN-1:0]         mc_wdata;
  logic                    rf_we;
  logic [4:0]              rf_waddr;
  logic [XLEN-1:0]         rf_wdata;
  logic [$clog2(DEPTH):0]  fifo_count;

  modport slave (
    input  pl_rf_en, pl_rd, pl_wdata, mc_valid, mc_rd, mc_wdata,
    output pl_stall, mc_ready, rf_we, rf_waddr, rf_wdata, fifo_count
  );

  modport master (
    output pl_rf_en, pl_rd, pl_wdata, mc_valid, mc_rd, mc_wdata,
    input  pl_stall, mc_ready, rf_we, rf_waddr, rf_wdata, fifo_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the
// in-order pipeline writeback and out-of-band multi-cycle (mul/div) results.
// Multi-cycle results queue in a DEPTH-entry FIFO and drain into free slots;
// a head entry that has waited MAX_WAIT cycles (or a full FIFO) forces a
// FIFO grant and stalls the pipeline write for one cycle.
// Optional feature macro: WB_PORT_ARBITER_STATS_EN adds stall_cnt and
// conflict_cnt performance counters.
module wb_port_arbiter #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef WB_PORT_ARBITER_STATS_EN
  wb_port_arbiter_if.slave     bus,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          conflict_cnt
`else
  wb_port_arbiter_if.slave     bus
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [WW-1:0]   wait_cnt;

  logic            pl_req;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic            grant_pl;
  entry_t          head;

  // Request qualification and arbitration decision for this cycle
  always_comb begin
    pl_req   = bus.pl_rf_en && (bus.pl_rd != 5'd0);
    empty    = (count == '0);
    full     = (count == CW'(DEPTH));
    push     = bus.mc_valid && !full && (bus.mc_rd != 5'd0);
    pop      = !empty && (!pl_req || (wait_cnt == WW'(MAX_WAIT)) || full);
    grant_pl = pl_req && !pop;
    head     = mem[rd_ptr];
  end

  assign bus.mc_ready   = !full;
  assign bus.pl_stall   = pop && pl_req;
  assign bus.fifo_count = count;

  // FIFO storage; written only on accepted, non-x0 results
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{rd: bus.mc_rd, data: bus.mc_wdata};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Head age: cleared when the head leaves or nothing is queued, saturates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (pop || empty) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WW'(MAX_WAIT)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Registered register-file write port; address/data hold when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
    end else if (pop) begin
      bus.rf_we    <= 1'b1;
      bus.rf_waddr <= head.rd;
      bus.rf_wdata <= head.data;
    end else if (grant_pl) begin
      bus.rf_we    <= 1'b1;
      bus.rf_waddr <= bus.pl_rd;
      bus.rf_wdata <= bus.pl_wdata;
    end else begin
      bus.rf_we    <= 1'b0;
    end
  end

`ifdef WB_PORT_ARBITER_STATS_EN
  // Wrapping performance counters for forced stalls and port conflicts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt    <= '0;
      conflict_cnt <= '0;
    end else begin
      if (bus.pl_stall)     stall_cnt    <= stall_cnt + 1'b1;
      if (pl_req && !empty) conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
`endif

endmodule
